// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared state encoding, instruction classes, field offsets and flag indices for the sequencer.
package cpu_seq_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_READ, S_EXEC, S_WRITE, S_RETIRE, S_JUMP, S_DONE
    } state_e;
    localparam logic [2:0] CLS_ALU  = 3'd0;
    localparam logic [2:0] CLS_LDI  = 3'd1;
    localparam logic [2:0] CLS_JMP  = 3'd2;
    localparam logic [2:0] CLS_JIF  = 3'd3;
    localparam logic [2:0] CLS_HALT = 3'd4;
    localparam int OPC_LSB  = 15;
    localparam int CLS_LSB  = 12;
    localparam int ADDR_LSB = 0;
    localparam int FLG_ZA = 0;
    localparam int FLG_ZB = 1;
    localparam int FLG_EQ = 2;
    localparam int FLG_GT = 3;
    localparam int FLG_LT = 4;
endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: program-loader handshake and instruction-memory write/address port.
interface cpu_sequencer_if #(parameter int ADDR_W = 12, parameter int INSTR_W = 19);
    logic               ld_valid;
    logic               ld_ready;
    logic [ADDR_W-1:0]  ld_addr;
    logic [INSTR_W-1:0] ld_data;
    logic               im_we;
    logic [ADDR_W-1:0]  im_addr;
    logic [INSTR_W-1:0] im_wdata;
    modport master (output ld_valid, ld_addr, ld_data, input ld_ready, im_we, im_addr, im_wdata);
    modport slave  (input ld_valid, ld_addr, ld_data, output ld_ready, im_we, im_addr, im_wdata);
endinterface

// File: rtl/cpu_sequencer_retire_ctr.sv
// seq_retire_ctr: retired-instruction counter with clear, saturating increment and limit look-ahead.
module seq_retire_ctr #(parameter int ADDR_W = 12, parameter int LIMIT = 4095) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);
    localparam logic [ADDR_W-1:0] LIM = ADDR_W'(LIMIT);
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    assign cnt_d = clr_i ? '0 : (inc_i && cnt_q != LIM) ? cnt_q + 1'b1 : cnt_q;
    // hit_o flags that the pending increment reaches the limit
    assign hit_o = cnt_q + 1'b1 == LIM;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute control FSM with registered datapath strobes and loader arbitration.
// Optional SEQ_SINGLE_STEP_EN adds step_mode/step so FETCH waits for one step pulse per instruction.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int INSTR_W     = 19,
    parameter int INSTR_LIMIT = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              timeout,
    cpu_sequencer_if.slave    bus,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [3:0]        ir_opcode,
    input  logic [2:0]        ir_cls,
    input  logic              za,
    input  logic              zb,
    input  logic              eq,
    input  logic              gt,
    input  logic              lt,
    output logic              load_ir,
    output logic              load_pc,
    output logic              inc_pc,
    output logic              load_a,
    output logic              load_b,
    output logic              load_c,
    output logic              we_dm,
    output logic              sel_a,
    output logic              sel_b,
    output logic              mode,
    output logic [2:0]        alu_op
);
    state_e state_q, state_d;
    logic issued_q, issue, go, taken, hit, clr, retire;
    logic [7:0] flag_vec;
    always_comb begin
        flag_vec = '0;
        flag_vec[FLG_ZA] = za;
        flag_vec[FLG_ZB] = zb;
        flag_vec[FLG_EQ] = eq;
        flag_vec[FLG_GT] = gt;
        flag_vec[FLG_LT] = lt;
    end
    assign taken = flag_vec[ir_opcode[2:0]];
`ifdef SEQ_SINGLE_STEP_EN
    assign go = !step_mode || (state_q == S_FETCH && step);
`else
    assign go = 1'b1;
`endif
    // issued_q survives a freeze so FETCH leaves only after its single load_ir
    assign issue  = state_d == S_FETCH && go;
    assign clr    = state_q == S_IDLE && state_d == S_FETCH;
    assign retire = state_q == S_RETIRE || state_q == S_JUMP;
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:           state_d = (start && !bus.ld_valid) ? S_FETCH : S_IDLE;
            S_FETCH:          state_d = issued_q ? S_DECODE : S_FETCH;
            S_DECODE:         state_d = ir_cls == CLS_ALU ? S_READ : ir_cls == CLS_LDI ? S_EXEC :
                                        ir_cls == CLS_JMP ? S_JUMP : ir_cls == CLS_JIF ? (taken ? S_JUMP : S_RETIRE) :
                                        ir_cls == CLS_HALT ? S_DONE : S_RETIRE;
            S_READ:           state_d = S_EXEC;
            S_EXEC:           state_d = S_WRITE;
            S_WRITE:          state_d = S_RETIRE;
            S_RETIRE, S_JUMP: state_d = hit ? S_DONE : S_FETCH;
            default:          state_d = S_IDLE;
        endcase
    end
    seq_retire_ctr #(.ADDR_W(ADDR_W), .LIMIT(INSTR_LIMIT)) u_ctr (
        .clk(clk), .rst(rst), .clr_i(en && clr), .inc_i(en && retire), .hit_o(hit)
    );
    // strobes are registered from the next state, so a frozen cycle simply emits zeros
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            issued_q <= 1'b0;
            err      <= 1'b0;
            timeout  <= 1'b0;
            {load_ir, load_pc, inc_pc, load_a, load_b, load_c, we_dm, sel_a, mode, alu_op, done} <= '0;
        end else if (en) begin
            state_q  <= state_d;
            issued_q <= issue;
            err      <= !clr && (err || (state_q == S_DECODE && ir_cls > CLS_HALT));
            timeout  <= !clr && (timeout || (retire && hit));
            load_ir  <= issue;
            load_pc  <= state_d == S_JUMP;
            inc_pc   <= state_d == S_RETIRE;
            load_a   <= state_d == S_READ;
            load_b   <= state_d == S_READ;
            load_c   <= state_d == S_EXEC;
            we_dm    <= state_d == S_WRITE;
            sel_a    <= state_d == S_EXEC && ir_cls == CLS_LDI;
            mode     <= state_d == S_EXEC && ir_opcode[3];
            alu_op   <= state_d == S_EXEC ? ir_opcode[2:0] : 3'd0;
            done     <= state_d == S_DONE;
        end else begin
            {load_ir, load_pc, inc_pc, load_a, load_b, load_c, we_dm, sel_a, mode, alu_op, done} <= '0;
        end
    end
    assign sel_b        = 1'b0;
    assign busy         = state_q != S_IDLE;
    assign bus.ld_ready = state_q == S_IDLE;
    assign bus.im_we    = bus.ld_valid && bus.ld_ready;
    assign bus.im_addr  = bus.ld_ready ? bus.ld_addr : pc_in;
    assign bus.im_wdata = INSTR_W'(bus.ld_data);
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed and random runs against an instruction-level model of the strobe sequence.
module tb_cpu_sequencer;
    import cpu_seq_pkg::*;
    localparam int AW = 12, IW = 19, LIM = 3;
    localparam logic [13:0] V_LIR = 14'h1000, V_LPC = 14'h0800, V_INC = 14'h0400, V_LAB = 14'h0300;
    localparam logic [13:0] V_LC = 14'h0080, V_WE = 14'h0040, V_SA = 14'h0020, V_MODE = 14'h0010, V_DN = 14'h0001;
    logic clk = 1'b0, rst = 1'b1, en = 1'b1, start = 1'b0;
    logic busy, done, err, timeout;
    logic load_ir, load_pc, inc_pc, load_a, load_b, load_c, we_dm, sel_a, sel_b, mode;
    logic [2:0] alu_op;
    logic [AW-1:0] pc = '0;
    logic [IW-1:0] ir = '0;
    logic [4:0] fl = '0;
    logic pc_ld = 1'b0;
    logic [AW-1:0] pc_ld_val = '0;
    logic [IW-1:0] imem [4096];
    logic [IW-1:0] prog [4096];
    logic [13:0] exp_q [$];
    bit exp_err, exp_to;
    int n_tests = 0, n_fail = 0;
    cpu_sequencer_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();
`ifdef SEQ_SINGLE_STEP_EN
    logic step_mode = 1'b0, step = 1'b0;
`endif
    cpu_sequencer #(.ADDR_W(AW), .INSTR_W(IW), .INSTR_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start),
`ifdef SEQ_SINGLE_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .busy(busy), .done(done), .err(err), .timeout(timeout), .bus(bus), .pc_in(pc),
        .ir_opcode(ir[OPC_LSB+:4]), .ir_cls(ir[CLS_LSB+:3]),
        .za(fl[FLG_ZA]), .zb(fl[FLG_ZB]), .eq(fl[FLG_EQ]), .gt(fl[FLG_GT]), .lt(fl[FLG_LT]),
        .load_ir(load_ir), .load_pc(load_pc), .inc_pc(inc_pc), .load_a(load_a), .load_b(load_b),
        .load_c(load_c), .we_dm(we_dm), .sel_a(sel_a), .sel_b(sel_b), .mode(mode), .alu_op(alu_op)
    );
    wire [13:0] act = {sel_b, load_ir, load_pc, inc_pc, load_a, load_b, load_c, we_dm, sel_a, mode, alu_op, done};
    always #5 clk = ~clk;
    // minimal datapath: instruction memory, IR and PC driven by the strobes
    always @(posedge clk) begin
        if (bus.im_we) imem[bus.im_addr] <= bus.im_wdata;
        if (load_ir) ir <= imem[pc];
        if (pc_ld) pc <= pc_ld_val;
        else if (load_pc) pc <= ir[ADDR_LSB+:AW];
        else if (inc_pc) pc <= pc + 1'b1;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_tests++;
        assert (got === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp_v);
        end
    endtask
    function automatic logic [IW-1:0] mk(input logic [3:0] o, input logic [2:0] c, input logic [AW-1:0] a);
        return {o, c, a};
    endfunction
    // expected per-cycle strobes of a whole run, walked instruction by instruction
    function automatic void build(input logic [AW-1:0] spc);
        logic [AW-1:0] p = spc;
        logic [IW-1:0] w;
        logic [3:0] o;
        logic [2:0] c;
        logic [7:0] fx;
        int n = 0;
        bit fin = 0, jmp;
        exp_q.delete();
        exp_err = 0;
        exp_to = 0;
        fx = {3'b000, fl};
        while (!fin) begin
            w = prog[p];
            o = w[OPC_LSB+:4];
            c = w[CLS_LSB+:3];
            jmp = c == 3'd2 || (c == 3'd3 && fx[o[2:0]]);
            exp_q.push_back(V_LIR);
            exp_q.push_back('0);
            if (c == 3'd0) exp_q.push_back(V_LAB);
            if (c <= 3'd1) begin
                exp_q.push_back(V_LC | (c == 3'd1 ? V_SA : 14'h0) | (o[3] ? V_MODE : 14'h0) | (14'(o[2:0]) << 1));
                exp_q.push_back(V_WE);
            end
            if (c == 3'd4) begin
                exp_q.push_back(V_DN);
                fin = 1;
            end else begin
                exp_q.push_back(jmp ? V_LPC : V_INC);
                if (c >= 3'd5) exp_err = 1;
                p = jmp ? w[ADDR_LSB+:AW] : p + 1'b1;
                n++;
                if (n == LIM) begin
                    exp_q.push_back(V_DN);
                    exp_to = 1;
                    fin = 1;
                end
            end
        end
    endfunction
    task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        prog[a] = d;
        #1;
        chk("ld_we", bus.im_we, 1);
        chk("ld_addr", bus.im_addr, a);
        chk("ld_data", bus.im_wdata, d);
        @(negedge clk);
        bus.ld_valid = 1'b0;
    endtask
    task automatic run(input logic [AW-1:0] spc, input int stall_at, input int rst_at);
        int idx = 0;
        logic [13:0] e;
        pc_ld = 1'b1;
        pc_ld_val = spc;
        @(negedge clk);
        pc_ld = 1'b0;
        build(spc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("strobes", act, e);
            chk("busy", busy, 1);
            chk("ld_ready_run", bus.ld_ready, 0);
            chk("im_addr_pc", bus.im_addr, pc);
            if (idx == 0) begin
                chk("err_clr", err, 0);
                chk("to_clr", timeout, 0);
            end
            if (idx == rst_at) begin
                chk("pre_rst_err", err, exp_err);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_strobes", act, 0);
                chk("rst_busy", busy, 0);
                chk("rst_err", err, 0);
                chk("rst_to", timeout, 0);
                chk("rst_ld_ready", bus.ld_ready, 1);
                return;
            end
            if (idx == stall_at) begin
                en = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("frz_strobes", act, 0);
                    chk("frz_busy", busy, 1);
                end
                en = 1'b1;
            end
            @(negedge clk);
            idx++;
        end
        chk("end_busy", busy, 0);
        chk("end_done", done, 0);
        chk("end_err", err, exp_err);
        chk("end_to", timeout, exp_to);
    endtask
    initial begin
        bus.ld_valid = 1'b0;
        bus.ld_addr = '0;
        bus.ld_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy0", busy, 0);
        chk("rst_act0", act, 0);
        chk("rst_err0", err, 0);
        chk("rst_to0", timeout, 0);
        chk("rst_rdy0", bus.ld_ready, 1);
        rst = 1'b0;
        @(negedge clk);
        load(12'd0, mk(4'h1, 3'd0, 12'h011));
        load(12'd1, mk(4'h2, 3'd1, 12'h022));
        load(12'd2, mk(4'h3, 3'd2, 12'h033));
        start = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_addr = 12'd3;
        bus.ld_data = mk(4'h0, 3'd4, 12'h0);
        prog[3] = bus.ld_data;
        #1;
        chk("ld_start_we", bus.im_we, 1);
        @(negedge clk);
        start = 1'b0;
        bus.ld_valid = 1'b0;
        chk("ld_start_busy", busy, 0);
        chk("ld_start_rdy", bus.ld_ready, 1);
        load(12'd5, mk(4'b1010, CLS_ALU, 12'd0));
        load(12'd6, mk(4'h0, CLS_HALT, 12'd0));
        run(12'd5, 3, -1);
        load(12'd10, mk(4'b0011, CLS_JIF, 12'd20));
        load(12'd11, mk(4'h0, CLS_HALT, 12'd0));
        load(12'd20, mk(4'h0, CLS_HALT, 12'd0));
        fl = 5'b01000;
        run(12'd10, -1, -1);
        fl = 5'b10111;
        run(12'd10, -1, -1);
        load(12'd0, mk(4'h0, 3'd6, 12'd0));
        load(12'd1, mk(4'h0, CLS_HALT, 12'd0));
        run(12'd0, -1, -1);
        load(12'd8, mk(4'h0, CLS_JMP, 12'd8));
        run(12'd8, -1, -1);
        load(12'd1, mk(4'b0101, CLS_ALU, 12'd0));
        load(12'd2, mk(4'h0, CLS_HALT, 12'd0));
        run(12'd0, -1, 5);
        @(negedge clk);
        for (int r = 0; r < 20; r++) begin
            for (int a = 0; a < 40; a++)
                load(AW'(a), mk(4'($urandom), 3'($urandom), AW'($urandom_range(0, 31))));
            fl = 5'($urandom);
            run(AW'($urandom_range(0, 15)), ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 8)) : -1, -1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
